axi4_mgr_arbiter: RTL and testbench

Shares one downstream AXI4 manager port between NUM_MGR upstream AXI4 managers, typically several axi4bfm VProc nodes driving a single memory model or interconnect. Round-robin arbitration grants one requester a complete transaction (single or burst read or write) at a time, holding the grant until the transaction's response completes. Upstream and downstream channels use the same reduced AXI4 subset as the BFM: no IDs, no rlast. Read completion is found by counting beats against the latched arlen.

---
 rtl/axi4_mgr_arbiter.sv | 146 ++++++++++++++
 tb/tb_axi4_mgr_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axi4_mgr_arbiter.sv
// axi4_mgr_arbiter: round-robin sharing of one downstream AXI4 manager port among NUM_MGR upstream managers
module axi4_mgr_arbiter #(
  parameter int NUM_MGR   = 2,
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_MGR*ADDRWIDTH-1:0]     m_awaddr,
  input  logic [NUM_MGR*8-1:0]             m_awlen,
  input  logic [NUM_MGR*3-1:0]             m_awprot,
  input  logic [NUM_MGR-1:0]               m_awvalid,
  output logic [NUM_MGR-1:0]               m_awready,
  input  logic [NUM_MGR*ADDRWIDTH-1:0]     m_araddr,
  input  logic [NUM_MGR*8-1:0]             m_arlen,
  input  logic [NUM_MGR*3-1:0]             m_arprot,
  input  logic [NUM_MGR-1:0]               m_arvalid,
  output logic [NUM_MGR-1:0]               m_arready,
  input  logic [NUM_MGR*DATAWIDTH-1:0]     m_wdata,
  input  logic [NUM_MGR*DATAWIDTH/8-1:0]   m_wstrb,
  input  logic [NUM_MGR-1:0]               m_wlast,
  input  logic [NUM_MGR-1:0]               m_wvalid,
  output logic [NUM_MGR-1:0]               m_wready,
  output logic [NUM_MGR-1:0]               m_bvalid,
  input  logic [NUM_MGR-1:0]               m_bready,
  output logic [NUM_MGR-1:0]               m_rvalid,
  input  logic [NUM_MGR-1:0]               m_rready,
  output logic [DATAWIDTH-1:0]             m_rdata,
  output logic [ADDRWIDTH-1:0]             s_awaddr,
  output logic [7:0]                       s_awlen,
  output logic [2:0]                       s_awprot,
  output logic                             s_awvalid,
  input  logic                             s_awready,
  output logic [ADDRWIDTH-1:0]             s_araddr,
  output logic [7:0]                       s_arlen,
  output logic [2:0]                       s_arprot,
  output logic                             s_arvalid,
  input  logic                             s_arready,
  output logic [DATAWIDTH-1:0]             s_wdata,
  output logic [DATAWIDTH/8-1:0]           s_wstrb,
  output logic                             s_wlast,
  output logic                             s_wvalid,
  input  logic                             s_wready,
  input  logic                             s_bvalid,
  output logic                             s_bready,
  input  logic                             s_rvalid,
  output logic                             s_rready,
  input  logic [DATAWIDTH-1:0]             s_rdata,
  output logic [NUM_MGR-1:0]               grant,
  output logic                             busy
);
  localparam int IW = (NUM_MGR > 2) ? 2 : 1;
  localparam int SW = DATAWIDTH / 8;
  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;
  state_t state, state_d;
  logic [IW-1:0] gidx, rr_ptr, sel, cand;
  logic found;
  logic [NUM_MGR-1:0] req;
  logic [7:0] arlen_q;
  logic [8:0] beat_cnt;
  logic aw_done, w_done, ar_done;
  logic aw_act, w_act, ar_act, aw_hs, w_hs, ar_hs, b_hs, r_hs, r_last;
  assign req = m_awvalid | m_arvalid;
  always_comb begin
    sel = '0;
    cand = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_MGR; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_MGR);
      if (!found && req[cand]) begin
        sel = cand;
        found = 1'b1;
      end
    end
  end
  assign aw_act = state == WRITE && !aw_done;
  assign w_act  = state == WRITE && !w_done;
  assign ar_act = state == READ && !ar_done;
  assign s_awvalid = aw_act & m_awvalid[gidx];
  assign s_awaddr  = s_awvalid ? m_awaddr[gidx*ADDRWIDTH +: ADDRWIDTH] : '0;
  assign s_awlen   = s_awvalid ? m_awlen[gidx*8 +: 8] : '0;
  assign s_awprot  = s_awvalid ? m_awprot[gidx*3 +: 3] : '0;
  assign m_awready = (aw_act & s_awready) ? grant : '0;
  assign s_wvalid  = w_act & m_wvalid[gidx];
  assign s_wdata   = s_wvalid ? m_wdata[gidx*DATAWIDTH +: DATAWIDTH] : '0;
  assign s_wstrb   = s_wvalid ? m_wstrb[gidx*SW +: SW] : '0;
  assign s_wlast   = s_wvalid & m_wlast[gidx];
  assign m_wready  = (w_act & s_wready) ? grant : '0;
  assign s_bready  = state == WRESP && m_bready[gidx];
  assign m_bvalid  = (state == WRESP && s_bvalid) ? grant : '0;
  assign s_arvalid = ar_act & m_arvalid[gidx];
  assign s_araddr  = s_arvalid ? m_araddr[gidx*ADDRWIDTH +: ADDRWIDTH] : '0;
  assign s_arlen   = s_arvalid ? m_arlen[gidx*8 +: 8] : '0;
  assign s_arprot  = s_arvalid ? m_arprot[gidx*3 +: 3] : '0;
  assign m_arready = (ar_act & s_arready) ? grant : '0;
  assign s_rready  = state == READ && m_rready[gidx];
  assign m_rvalid  = (state == READ && s_rvalid) ? grant : '0;
  assign m_rdata   = s_rdata;
  assign busy      = state != IDLE;
  assign aw_hs  = s_awvalid & s_awready;
  assign w_hs   = s_wvalid & s_wready & s_wlast;
  assign ar_hs  = s_arvalid & s_arready;
  assign b_hs   = s_bvalid & s_bready;
  assign r_hs   = s_rvalid & s_rready;
  assign r_last = r_hs && beat_cnt == {1'b0, arlen_q};
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  state_d = found ? (m_awvalid[sel] ? WRITE : READ) : IDLE;
      WRITE: state_d = ((aw_done | aw_hs) && (w_done | w_hs)) ? WRESP : WRITE;
      WRESP: state_d = b_hs ? IDLE : WRESP;
      READ:  state_d = r_last ? IDLE : READ;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gidx <= '0;
      rr_ptr <= IW'(NUM_MGR - 1);
      grant <= '0;
      arlen_q <= '0;
      beat_cnt <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      ar_done <= 1'b0;
    end else begin
      state <= state_d;
      aw_done <= aw_done | aw_hs;
      w_done <= w_done | w_hs;
      ar_done <= ar_done | ar_hs;
      if (r_hs) beat_cnt <= r_last ? '0 : beat_cnt + 9'd1;
      if (state != IDLE && state_d == IDLE) grant <= '0;
      if (state == IDLE && found) begin
        gidx <= sel;
        rr_ptr <= sel;
        grant <= NUM_MGR'(1) << sel;
        arlen_q <= m_arlen[sel*8 +: 8];
        beat_cnt <= '0;
        aw_done <= 1'b0;
        w_done <= 1'b0;
        ar_done <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi4_mgr_arbiter.sv
// tb_axi4_mgr_arbiter: directed scenario checks of the 4-requester arbiter
module tb_axi4_mgr_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [127:0] m_awaddr, m_araddr, m_wdata;
  logic [31:0] m_awlen, m_arlen;
  logic [11:0] m_awprot, m_arprot;
  logic [15:0] m_wstrb;
  logic [3:0] m_awvalid, m_arvalid, m_wvalid, m_wlast, m_bready, m_rready;
  logic [3:0] m_awready, m_arready, m_wready, m_bvalid, m_rvalid, grant;
  logic [31:0] m_rdata, s_awaddr, s_araddr, s_wdata, s_rdata;
  logic [7:0] s_awlen, s_arlen;
  logic [2:0] s_awprot, s_arprot;
  logic [3:0] s_wstrb;
  logic s_awvalid, s_awready, s_arvalid, s_arready, s_wlast, s_wvalid, s_wready;
  logic s_bvalid, s_bready, s_rvalid, s_rready, busy;
  int n_cmp = 0, n_err = 0;

  axi4_mgr_arbiter #(.NUM_MGR(4), .ADDRWIDTH(32), .DATAWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .grant(grant), .busy(busy));

  always #5 clk = ~clk;

  task automatic clear_inputs();
    m_awaddr = '0; m_araddr = '0; m_wdata = '0; m_awlen = '0; m_arlen = '0;
    m_awprot = '0; m_arprot = '0; m_wstrb = '0;
    m_awvalid = '0; m_arvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0; m_rready = '0;
    s_awready = 0; s_arready = 0; s_wready = 0; s_bvalid = 0; s_rvalid = 0; s_rdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (grant !== 4'b0) begin n_err++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if ({s_awvalid, s_arvalid, s_wvalid, s_bready, s_rready} !== 5'b0) begin n_err++;
      $display("FAIL reset_s_strobes: got %b expected 00000", {s_awvalid, s_arvalid, s_wvalid, s_bready, s_rready}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    m_awvalid[1] = 1; m_awaddr[32 +: 32] = 32'h1000; m_wvalid[1] = 1; m_wlast[1] = 1;
    m_wdata[32 +: 32] = 32'hDEADBEEF; m_wstrb[4 +: 4] = 4'hF;
    #1;
    n_cmp++; if (s_awvalid !== 1'b0) begin n_err++; $display("FAIL sw_latency: got %b expected 0", s_awvalid); end
    @(negedge clk);
    #1;
    n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL sw_grant: got %b expected 0010", grant); end
    n_cmp++; if ({s_awvalid, s_awaddr} !== {1'b1, 32'h1000}) begin n_err++; $display("FAIL sw_aw: got %b %h expected 1 00001000", s_awvalid, s_awaddr); end
    n_cmp++; if ({s_wvalid, s_wlast, s_wdata, s_wstrb} !== {2'b11, 32'hDEADBEEF, 4'hF}) begin n_err++;
      $display("FAIL sw_w: got %b%b %h %h expected 11 deadbeef f", s_wvalid, s_wlast, s_wdata, s_wstrb); end
    s_awready = 1; s_wready = 1;
    #1;
    n_cmp++; if ({m_awready, m_wready} !== 8'b0010_0010) begin n_err++; $display("FAIL sw_ready: got %b %b expected 0010 0010", m_awready, m_wready); end
    @(negedge clk);
    m_awvalid = '0; m_wvalid = '0; s_awready = 0; s_wready = 0; s_bvalid = 1; m_bready[1] = 1;
    #1;
    n_cmp++; if ({m_bvalid, s_bready, grant} !== {4'b0010, 1'b1, 4'b0010}) begin n_err++;
      $display("FAIL sw_b: got %b %b %b expected 0010 1 0010", m_bvalid, s_bready, grant); end
    @(negedge clk);
    s_bvalid = 0;
    #1;
    n_cmp++; if ({busy, grant, m_bvalid} !== 9'b0) begin n_err++; $display("FAIL sw_idle: got %b %b %b expected 0 0000 0000", busy, grant, m_bvalid); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_g [4];
    exp_g = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
    @(negedge clk);
    m_awvalid = 4'b0011; m_wvalid = 4'b0011; m_wlast = 4'b0011; m_bready = 4'b0011;
    s_awready = 1; s_wready = 1; s_bvalid = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      n_cmp++; if (grant !== exp_g[k]) begin n_err++; $display("FAIL rr_grant%0d: got %b expected %b", k, grant, exp_g[k]); end
      @(negedge clk); #1;
      n_cmp++; if (m_bvalid !== exp_g[k]) begin n_err++; $display("FAIL rr_bvalid%0d: got %b expected %b", k, m_bvalid, exp_g[k]); end
      @(negedge clk); #1;
      n_cmp++; if ({busy, grant} !== 5'b0) begin n_err++; $display("FAIL rr_idle%0d: got %b %b expected 0 0000", k, busy, grant); end
    end
    clear_inputs();
  endtask

  task automatic test_read_burst();
    int beats = 0, cyc = 0;
    @(negedge clk);
    m_arvalid[2] = 1; m_araddr[64 +: 32] = 32'h2000; m_arlen[16 +: 8] = 8'd3; m_rready[2] = 1; s_arready = 1;
    @(negedge clk); #1;
    n_cmp++; if ({grant, s_arvalid, s_araddr, s_arlen} !== {4'b0100, 1'b1, 32'h2000, 8'd3}) begin n_err++;
      $display("FAIL rd_ar: got %b %b %h %0d expected 0100 1 00002000 3", grant, s_arvalid, s_araddr, s_arlen); end
    while (beats < 4 && cyc < 20) begin
      @(negedge clk);
      m_arvalid = '0;
      s_rvalid = (cyc % 2 == 0);
      s_rdata = 32'hA000_0000 + 32'(cyc);
      #1;
      n_cmp++; if ({m_rvalid, m_rdata} !== {(s_rvalid ? 4'b0100 : 4'b0000), 32'hA000_0000 + 32'(cyc)}) begin n_err++;
        $display("FAIL rd_beat_c%0d: got %b %h expected %b %h", cyc, m_rvalid, m_rdata, s_rvalid ? 4'b0100 : 4'b0000, 32'hA000_0000 + 32'(cyc)); end
      if (s_rvalid && s_rready) beats++;
      cyc++;
    end
    n_cmp++; if (beats !== 4) begin n_err++; $display("FAIL rd_beats: got %0d expected 4", beats); end
    @(negedge clk);
    s_rvalid = 0;
    #1;
    n_cmp++; if ({busy, grant} !== 5'b0) begin n_err++; $display("FAIL rd_done: got %b %b expected 0 0000", busy, grant); end
    clear_inputs();
  endtask

  task automatic test_w_before_aw();
    @(negedge clk);
    m_awvalid[3] = 1; m_awaddr[96 +: 32] = 32'h3000; m_wvalid[3] = 1; m_wlast[3] = 1;
    m_wdata[96 +: 32] = 32'h12345678; m_bready[3] = 1; s_wready = 1;
    @(negedge clk); #1;
    n_cmp++; if ({grant, s_awvalid, s_wvalid, m_wready} !== {4'b1000, 2'b11, 4'b1000}) begin n_err++;
      $display("FAIL wa_start: got %b %b %b %b expected 1000 1 1 1000", grant, s_awvalid, s_wvalid, m_wready); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      n_cmp++; if ({s_awvalid, s_wvalid, m_wready, s_wdata} !== {2'b10, 4'b0000, 32'h0}) begin n_err++;
        $display("FAIL wa_hold%0d: got %b %b %b %h expected 1 0 0000 00000000", k, s_awvalid, s_wvalid, m_wready, s_wdata); end
    end
    @(negedge clk);
    s_awready = 1;
    #1;
    n_cmp++; if ({s_awvalid, m_awready} !== {1'b1, 4'b1000}) begin n_err++; $display("FAIL wa_aw_hs: got %b %b expected 1 1000", s_awvalid, m_awready); end
    @(negedge clk);
    s_awready = 0; m_awvalid = '0; m_wvalid = '0; s_bvalid = 1;
    #1;
    n_cmp++; if ({s_awvalid, m_bvalid, s_bready} !== {1'b0, 4'b1000, 1'b1}) begin n_err++;
      $display("FAIL wa_wresp: got %b %b %b expected 0 1000 1", s_awvalid, m_bvalid, s_bready); end
    @(negedge clk);
    s_bvalid = 0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wa_idle: got %b expected 0", busy); end
    clear_inputs();
  endtask

  task automatic test_write_over_read();
    @(negedge clk);
    m_awvalid[0] = 1; m_arvalid[0] = 1; m_awaddr[0 +: 32] = 32'h5000; m_araddr[0 +: 32] = 32'h4000;
    m_wvalid[0] = 1; m_wlast[0] = 1; m_bready[0] = 1; m_rready[0] = 1;
    s_awready = 1; s_wready = 1; s_arready = 1; s_bvalid = 1;
    @(negedge clk); #1;
    n_cmp++; if ({grant, s_awvalid, s_arvalid, s_awaddr} !== {4'b0001, 2'b10, 32'h5000}) begin n_err++;
      $display("FAIL wr_first: got %b %b %b %h expected 0001 1 0 00005000", grant, s_awvalid, s_arvalid, s_awaddr); end
    @(negedge clk);
    m_awvalid[0] = 0; m_wvalid[0] = 0;
    #1;
    n_cmp++; if (m_bvalid !== 4'b0001) begin n_err++; $display("FAIL wr_bvalid: got %b expected 0001", m_bvalid); end
    @(negedge clk);
    s_bvalid = 0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_turn: got %b expected 0", busy); end
    @(negedge clk);
    s_rvalid = 1; s_rdata = 32'hCAFE_F00D;
    #1;
    n_cmp++; if ({grant, s_arvalid, s_araddr, m_rvalid} !== {4'b0001, 1'b1, 32'h4000, 4'b0001}) begin n_err++;
      $display("FAIL rd_second: got %b %b %h %b expected 0001 1 00004000 0001", grant, s_arvalid, s_araddr, m_rvalid); end
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rd_single_done: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    m_arvalid[1] = 1; m_arlen[8 +: 8] = 8'd7; m_rready[1] = 1; s_arready = 1; s_rvalid = 1;
    repeat (3) @(negedge clk);
    m_arvalid = '0;
    #1;
    n_cmp++; if ({busy, grant, m_rvalid} !== {1'b1, 4'b0010, 4'b0010}) begin n_err++;
      $display("FAIL mr_before: got %b %b %b expected 1 0010 0010", busy, grant, m_rvalid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, grant, m_rvalid, s_rready, s_arvalid} !== 11'b0) begin n_err++;
      $display("FAIL mr_async: got %b %b %b %b %b expected all 0", busy, grant, m_rvalid, s_rready, s_arvalid); end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    m_awvalid = 4'b1001;
    @(negedge clk); #1;
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL mr_regrant: got %b expected 0001", grant); end
    clear_inputs();
    rst_n = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_read_burst();
    test_w_before_aw();
    test_write_over_read();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
